pmod_jstk2_multi: RTL and testbench

PMOD_JSTK2_MULTI -- requirements
Module: pmod_jstk2_multi

---
 rtl/pmod_jstk2_multi.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_pmod_jstk2_multi.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmod_jstk2_multi.sv
// SPI master for up to four Digilent PmodJSTK2 joysticks on one shared bus.
// Reads position/button data or sets the LED of one device per transaction,
// and can poll all devices in turn.
module pmod_jstk2_multi #(
  parameter int N_DEV       = 2,
  parameter int CLK_DIV     = 50,
  parameter int CS_SETUP    = 1500,
  parameter int BYTE_GAP    = 1000,
  parameter int POLL_PERIOD = 1000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_read,
  input  logic                 cmd_valid,
  input  logic [1:0]           req_dev,
  input  logic [23:0]          cmd_rgb,
  input  logic                 auto_poll,
  input  logic                 miso,
  output logic                 sck,
  output logic                 mosi,
  output logic [N_DEV-1:0]     cs_n,
  output logic [16*N_DEV-1:0]  x_position,
  output logic [16*N_DEV-1:0]  y_position,
  output logic [8*N_DEV-1:0]   fs_buttons,
  output logic [N_DEV-1:0]     btn_jstk,
  output logic [N_DEV-1:0]     btn_trigger,
  output logic                 data_valid,
  output logic [1:0]           valid_dev,
  output logic                 busy,
  output logic                 req_err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [31:0]          cnt_q, cnt_d;
  logic                 phase_q, phase_d;       // 0: sck low half, 1: sck high half
  logic [2:0]           bit_q, bit_d;
  logic [2:0]           byte_q, byte_d;
  logic [1:0]           dev_q, dev_d;
  logic                 is_read_q, is_read_d;
  logic [39:0]          tx_q, tx_d;
  logic [39:0]          rx_q, rx_d;
  logic                 sck_q, sck_d;
  logic                 mosi_q, mosi_d;
  logic [N_DEV-1:0]     cs_n_q, cs_n_d;
  logic [16*N_DEV-1:0]  x_q, x_d, y_q, y_d;
  logic [8*N_DEV-1:0]   fs_q, fs_d;
  logic [N_DEV-1:0]     jstk_q, jstk_d, trig_q, trig_d;
  logic                 dv_q, dv_d;
  logic [1:0]           vdev_q, vdev_d;
  logic                 err_q, err_d;
  logic [31:0]          poll_cnt_q, poll_cnt_d;
  logic                 pend_q, pend_d;
  logic [1:0]           poll_idx_q, poll_idx_d;

  logic                 go;
  logic                 go_read;
  logic [1:0]           go_dev;
  logic                 dev_ok;

  assign dev_ok = ({1'b0, req_dev} < 3'(N_DEV));

  // Next-state logic: request arbitration, bus sequencing, result capture, poll timer.
  always_comb begin
    // NOTE: every signal gets a default here so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    dev_d      = dev_q;
    is_read_d  = is_read_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    x_d        = x_q;
    y_d        = y_q;
    fs_d       = fs_q;
    jstk_d     = jstk_q;
    trig_d     = trig_q;
    dv_d       = 1'b0;
    vdev_d     = vdev_q;
    err_d      = 1'b0;
    poll_cnt_d = poll_cnt_q;
    pend_d     = pend_q;
    poll_idx_d = poll_idx_q;
    go         = 1'b0;
    go_read    = 1'b0;
    go_dev     = 2'd0;

    // Poll timer; dropping auto_poll forgets any tick not yet served.
    if (!auto_poll) begin
      poll_cnt_d = '0;
      pend_d     = 1'b0;
    end else if (poll_cnt_q == 32'(POLL_PERIOD - 1)) begin
      poll_cnt_d = '0;
    end else begin
      poll_cnt_d = poll_cnt_q + 32'd1;
    end

    case (state_q)
      ST_IDLE: begin
        // An LED command outranks a host read, which outranks a poll tick;
        // only the poll tick survives losing arbitration.
        if (cmd_valid) begin
          if (dev_ok) begin
            go      = 1'b1;
            go_read = 1'b0;
            go_dev  = req_dev;
          end else begin
            err_d = 1'b1;
          end
        end else if (start_read) begin
          if (dev_ok) begin
            go      = 1'b1;
            go_read = 1'b1;
            go_dev  = req_dev;
          end else begin
            err_d = 1'b1;
          end
        end else if (pend_q && auto_poll) begin
          go         = 1'b1;
          go_read    = 1'b1;
          go_dev     = poll_idx_q;
          pend_d     = 1'b0;
          poll_idx_d = (poll_idx_q == 2'(N_DEV - 1)) ? 2'd0 : poll_idx_q + 2'd1;
        end
        if (go) begin
          state_d   = ST_SETUP;
          cnt_d     = '0;
          phase_d   = 1'b0;
          bit_d     = '0;
          byte_d    = '0;
          dev_d     = go_dev;
          is_read_d = go_read;
          tx_d      = go_read ? 40'h0 : {8'h84, cmd_rgb, 8'h00};
          for (int k = 0; k < N_DEV; k++) begin
            if (2'(k) == go_dev) cs_n_d[k] = 1'b0;
          end
        end
      end

      ST_SETUP: begin
        if (cnt_q == 32'(CS_SETUP - 1)) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          mosi_d  = tx_q[39];
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_SHIFT: begin
        if (cnt_q != 32'(CLK_DIV - 1)) begin
          cnt_d = cnt_q + 32'd1;
        end else begin
          cnt_d = '0;
          if (!phase_q) begin
            // Rising sck: the slave has held miso stable through the low half.
            phase_d = 1'b1;
            sck_d   = 1'b1;
            rx_d    = {rx_q[38:0], miso};
          end else begin
            phase_d = 1'b0;
            sck_d   = 1'b0;
            tx_d    = {tx_q[38:0], 1'b0};
            if (bit_q != 3'd7) begin
              bit_d  = bit_q + 3'd1;
              mosi_d = tx_q[38];
            end else begin
              bit_d  = '0;
              mosi_d = 1'b0;
              if (byte_q == 3'd4) begin
                state_d = ST_DONE;
                cs_n_d  = '1;
                dv_d    = is_read_q;
                if (is_read_q) begin
                  vdev_d = dev_q;
                  for (int k = 0; k < N_DEV; k++) begin
                    if (2'(k) == dev_q) begin
                      x_d[16*k +: 16] = {rx_q[31:24], rx_q[39:32]};
                      y_d[16*k +: 16] = {rx_q[15:8],  rx_q[23:16]};
                      fs_d[8*k +: 8]  = rx_q[7:0];
                      jstk_d[k]       = rx_q[0];
                      trig_d[k]       = rx_q[1];
                    end
                  end
                end
              end else begin
                state_d = ST_GAP;
                byte_d  = byte_q + 3'd1;
              end
            end
          end
        end
      end

      ST_GAP: begin
        if (cnt_q == 32'(BYTE_GAP - 1)) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          mosi_d  = tx_q[39];
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // A tick landing while one is already pending is simply absorbed.
    if (auto_poll && poll_cnt_q == 32'(POLL_PERIOD - 1)) pend_d = 1'b1;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      bit_q      <= '0;
      byte_q     <= '0;
      dev_q      <= '0;
      is_read_q  <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      x_q        <= '0;
      y_q        <= '0;
      fs_q       <= '0;
      jstk_q     <= '0;
      trig_q     <= '0;
      dv_q       <= 1'b0;
      vdev_q     <= '0;
      err_q      <= 1'b0;
      poll_cnt_q <= '0;
      pend_q     <= 1'b0;
      poll_idx_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      dev_q      <= dev_d;
      is_read_q  <= is_read_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      x_q        <= x_d;
      y_q        <= y_d;
      fs_q       <= fs_d;
      jstk_q     <= jstk_d;
      trig_q     <= trig_d;
      dv_q       <= dv_d;
      vdev_q     <= vdev_d;
      err_q      <= err_d;
      poll_cnt_q <= poll_cnt_d;
      pend_q     <= pend_d;
      poll_idx_q <= poll_idx_d;
    end
  end

  // Shift registers for transmit and receive data.
  // NOTE: left unreset on purpose; they are loaded before use and only read
  // when the control path says their contents are valid.
  always_ff @(posedge clk) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
  end

  assign sck         = sck_q;
  assign mosi        = mosi_q;
  assign cs_n        = cs_n_q;
  assign x_position  = x_q;
  assign y_position  = y_q;
  assign fs_buttons  = fs_q;
  assign btn_jstk    = jstk_q;
  assign btn_trigger = trig_q;
  assign data_valid  = dv_q;
  assign valid_dev   = vdev_q;
  assign busy        = (state_q != ST_IDLE);
  assign req_err     = err_q;

endmodule

// File: tb/tb_pmod_jstk2_multi.sv
// Self-checking bench for pmod_jstk2_multi: a per-device SPI slave model,
// a MOSI capture, and a scoreboard of expected transactions.
module tb_pmod_jstk2_multi;

  localparam int N_DEV       = 2;
  localparam int CLK_DIV     = 2;
  localparam int CS_SETUP    = 4;
  localparam int BYTE_GAP    = 3;
  localparam int POLL_PERIOD = 600;
  localparam int TXN_LAT     = 1 + CS_SETUP + 80*CLK_DIV + 4*BYTE_GAP;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                start_read, cmd_valid, auto_poll, miso;
  logic [1:0]          req_dev;
  logic [23:0]         cmd_rgb;
  logic                sck, mosi, data_valid, busy, req_err;
  logic [N_DEV-1:0]    cs_n, btn_jstk, btn_trigger;
  logic [16*N_DEV-1:0] x_position, y_position;
  logic [8*N_DEV-1:0]  fs_buttons;
  logic [1:0]          valid_dev;

  pmod_jstk2_multi #(
    .N_DEV(N_DEV), .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP),
    .BYTE_GAP(BYTE_GAP), .POLL_PERIOD(POLL_PERIOD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_read(start_read), .cmd_valid(cmd_valid),
    .req_dev(req_dev), .cmd_rgb(cmd_rgb), .auto_poll(auto_poll), .miso(miso),
    .sck(sck), .mosi(mosi), .cs_n(cs_n), .x_position(x_position),
    .y_position(y_position), .fs_buttons(fs_buttons), .btn_jstk(btn_jstk),
    .btn_trigger(btn_trigger), .data_valid(data_valid), .valid_dev(valid_dev),
    .busy(busy), .req_err(req_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [1:0]  dev;
    bit          is_read;
    logic [39:0] mosi;
    int          t_req;     // request cycle, or -1 when latency is not checked
  } exp_t;

  exp_t        sb_q[$];
  logic [39:0] slv_data [N_DEV];
  logic [15:0] m_x [N_DEV];
  logic [15:0] m_y [N_DEV];
  logic [7:0]  m_fs [N_DEV];

  function automatic void model_clear();
    for (int k = 0; k < N_DEV; k++) begin
      m_x[k] = '0; m_y[k] = '0; m_fs[k] = '0;
    end
  endfunction

  // Compare every output vector of every device against the model.
  task automatic check_outputs(input string tag);
    logic [16*N_DEV-1:0] ex, ey;
    logic [8*N_DEV-1:0]  efs;
    logic [N_DEV-1:0]    ej, et;
    for (int k = 0; k < N_DEV; k++) begin
      ex[16*k +: 16] = m_x[k];
      ey[16*k +: 16] = m_y[k];
      efs[8*k +: 8]  = m_fs[k];
      ej[k]          = m_fs[k][0];
      et[k]          = m_fs[k][1];
    end
    check({tag, "_x"},    64'(x_position),  64'(ex));
    check({tag, "_y"},    64'(y_position),  64'(ey));
    check({tag, "_fs"},   64'(fs_buttons),  64'(efs));
    check({tag, "_jstk"}, 64'(btn_jstk),    64'(ej));
    check({tag, "_trig"}, 64'(btn_trigger), 64'(et));
  endtask

  // Slave model, MOSI capture and transaction monitor, all on the falling clk edge.
  logic [N_DEV-1:0] prev_cs = '1;
  logic             prev_sck = 1'b0;
  logic [N_DEV-1:0] low_mask;
  logic [39:0]      slv_sr, mosi_sr;
  int               onehot_bad = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_cs  = '1;
      prev_sck = 1'b0;
    end else begin
      if ($countones(~cs_n) > 1) onehot_bad++;
      if (prev_cs == '1 && cs_n != '1) begin
        low_mask = '0;
        mosi_sr  = '0;
        slv_sr   = '0;
        for (int k = 0; k < N_DEV; k++) if (!cs_n[k]) slv_sr = slv_data[k];
        miso = slv_sr[39];
      end
      if (cs_n != '1) low_mask = low_mask | ~cs_n;
      if (!prev_sck && sck) mosi_sr = {mosi_sr[38:0], mosi};
      if (prev_sck && !sck) begin
        slv_sr = {slv_sr[38:0], 1'b0};
        miso   = slv_sr[39];
      end
      if (prev_cs != '1 && cs_n == '1) begin
        check("txn_expected", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("mosi_bytes", 64'(mosi_sr), 64'(e.mosi));
          check("cs_mask", 64'(low_mask), 64'(1 << e.dev));
          check("data_valid", 64'(data_valid), 64'(e.is_read));
          if (e.is_read) begin
            check("valid_dev", 64'(valid_dev), 64'(e.dev));
            m_x[e.dev]  = {slv_data[e.dev][31:24], slv_data[e.dev][39:32]};
            m_y[e.dev]  = {slv_data[e.dev][15:8],  slv_data[e.dev][23:16]};
            m_fs[e.dev] = slv_data[e.dev][7:0];
            if (e.t_req >= 0) check("latency", 64'(cyc - e.t_req), 64'(TXN_LAT));
          end
          check_outputs("txn");
        end
      end else begin
        check("no_stray_dv", 64'(data_valid), 64'd0);
      end
      prev_cs  = cs_n;
      prev_sck = sck;
    end
  end

  task automatic push_exp(input logic [1:0] dev, input bit rd, input logic [39:0] mo, input int t);
    exp_t e;
    e.dev = dev; e.is_read = rd; e.mosi = mo; e.t_req = t;
    sb_q.push_back(e);
  endtask

  // One-cycle request pulse, driven on the falling edge.
  task automatic drive_req(input logic sr, input logic cv, input logic [1:0] dev, input logic [23:0] rgb);
    start_read = sr; cmd_valid = cv; req_dev = dev; cmd_rgb = rgb;
    @(negedge clk);
    start_read = 1'b0; cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    @(negedge clk);
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; start_read = 1'b0; cmd_valid = 1'b0; auto_poll = 1'b0;
    miso = 1'b0; req_dev = '0; cmd_rgb = '0;
    model_clear();
    slv_data[0] = 40'h80_00_80_00_00;
    slv_data[1] = 40'hC8_00_20_00_03;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 64'(cs_n), 64'h3);
    check("rst_sck", 64'(sck), 64'd0);
    check("rst_mosi", 64'(mosi), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dv", 64'(data_valid), 64'd0);
    check("rst_err", 64'(req_err), 64'd0);
    check("rst_vdev", 64'(valid_dev), 64'd0);
    check_outputs("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Read device 0, with latency measured from the request cycle.
    push_exp(2'd0, 1'b1, 40'h0, cyc);
    drive_req(1'b1, 1'b0, 2'd0, 24'h0);
    check("busy_after_accept", 64'(busy), 64'd1);
    check("cs_after_accept", 64'(cs_n), 64'h2);
    wait_idle(400);

    // Read device 1; device 0 results must stay put.
    push_exp(2'd1, 1'b1, 40'h0, cyc);
    drive_req(1'b1, 1'b0, 2'd1, 24'h0);
    wait_idle(400);

    // LED command with a simultaneous read that must be dropped.
    push_exp(2'd0, 1'b0, 40'h84_FF_80_01_00, -1);
    drive_req(1'b1, 1'b1, 2'd0, 24'hFF8001);
    wait_idle(400);

    // Out-of-range device: one req_err pulse and no bus activity.
    drive_req(1'b1, 1'b0, 2'd3, 24'h0);
    check("err_pulse", 64'(req_err), 64'd1);
    check("err_cs_n", 64'(cs_n), 64'h3);
    check("err_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("err_one_cycle", 64'(req_err), 64'd0);
    drive_req(1'b0, 1'b1, 2'd2, 24'h123456);
    check("err_pulse_cmd", 64'(req_err), 64'd1);
    check("err_cs_n_cmd", 64'(cs_n), 64'h3);

    // Requests arriving while busy are ignored.
    slv_data[0] = 40'h12_34_56_78_02;
    push_exp(2'd0, 1'b1, 40'h0, cyc);
    drive_req(1'b1, 1'b0, 2'd0, 24'h0);
    repeat (20) @(negedge clk);
    drive_req(1'b1, 1'b1, 2'd1, 24'hABCDEF);
    check("no_err_when_busy", 64'(req_err), 64'd0);
    wait_idle(400);

    // Auto-poll: two ticks serve device 0 then device 1.
    slv_data[1] = 40'hAB_CD_EF_01_FE;
    push_exp(2'd0, 1'b1, 40'h0, -1);
    push_exp(2'd1, 1'b1, 40'h0, -1);
    auto_poll = 1'b1;
    repeat (1300) @(negedge clk);
    auto_poll = 1'b0;
    wait_idle(400);
    check("poll_sb_drained", 64'(sb_q.size()), 64'd0);

    // Reset in the middle of byte 2 aborts without a result.
    push_exp(2'd1, 1'b1, 40'h0, cyc);
    drive_req(1'b1, 1'b0, 2'd1, 24'h0);
    repeat (CS_SETUP + 32*CLK_DIV + 2*BYTE_GAP + 6) @(negedge clk);
    check("busy_before_reset", 64'(busy), 64'd1);
    sb_q.delete();
    model_clear();
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_cs_n", 64'(cs_n), 64'h3);
    check("mid_rst_sck", 64'(sck), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_dv", 64'(data_valid), 64'd0);
    check_outputs("mid_rst");
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    check("post_rst_idle", 64'(busy), 64'd0);
    check("post_rst_cs_n", 64'(cs_n), 64'h3);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    check("cs_onehot", 64'(onehot_bad), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got cycle %0d expected < 200000", cyc);
    $fatal(1, "timeout");
  end

endmodule
